erase_sched: RTL and testbench

Multi-block erase scheduler that sequences the page-erase datapath (`erase_flash`) over a contiguous range of NAND blocks. It steps a block index from a start block for a requested count and presents each block's row address with `en_erase_page`. It consumes the bad-block verdict (`erase_addr_row_error`) and the status verdict (`erase_success`), skips bad blocks, and optionally marks failed blocks in the bad-block RAM. It sits between the host command decoder and `erase_flash`. The top flash FSM continues to drive `state` to `erase_flash` independently.

---
 rtl/erase_sched_if.sv | 21 ++
 rtl/erase_sched.sv | 123 ++++++++++++
 tb/tb_erase_sched.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/erase_sched_if.sv
// Flash-side bundle of the erase scheduler: page-erase handshake towards
// erase_flash plus the bad-block-table write port.
interface erase_sched_if;
  logic        en_erase_page;
  logic [23:0] erase_addr_row;
  logic [1:0]  erase_addr_row_error;
  logic [1:0]  erase_success;
  logic        bbt_wr_en;
  logic [11:0] bbt_wr_addr;
  logic        bbt_wr_data;

  modport master (
    output en_erase_page, erase_addr_row, bbt_wr_en, bbt_wr_addr, bbt_wr_data,
    input  erase_addr_row_error, erase_success
  );

  modport slave (
    input  en_erase_page, erase_addr_row, bbt_wr_en, bbt_wr_addr, bbt_wr_data,
    output erase_addr_row_error, erase_success
  );
endinterface

// File: rtl/erase_sched.sv
// Multi-block erase scheduler: walks a block range, drives erase_flash per block,
// skips bad blocks, optionally marks failed blocks bad, and keeps statistics.
module erase_sched #(
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd500000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [11:0]         first_block,
  input  logic [12:0]         block_count,
  input  logic                mark_bad_en,
  input  logic                abort,
  erase_sched_if.master       fl,
  output logic                busy,
  output logic                done,
  output logic [12:0]         erased_cnt,
  output logic [12:0]         skipped_cnt,
  output logic [12:0]         failed_cnt,
  output logic                timeout_flag
);

  typedef enum logic [2:0] {IDLE, CHECK, ERASE, MARK, GAP, DONE} state_t;

  state_t      state_reg, state_next;
  logic [11:0] block_reg;
  logic [12:0] remaining_reg;
  logic [19:0] tmo_reg;
  logic        mark_reg;
  logic [12:0] erased_reg, skipped_reg, failed_reg;
  logic        timeout_reg;

  logic        accept, skip_hit, pass_hit, fail_hit, tmo_hit;

  assign accept = (state_reg == IDLE) && start;

  always_comb begin
    state_next = state_reg;
    skip_hit   = 1'b0;
    pass_hit   = 1'b0;
    fail_hit   = 1'b0;
    tmo_hit    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = (block_count == 13'd0) ? DONE : CHECK;
      end
      CHECK: begin
        if (fl.erase_addr_row_error == 2'd2) begin
          skip_hit   = 1'b1;
          state_next = GAP;
        end else if (fl.erase_addr_row_error == 2'd1) begin
          state_next = ERASE;
        end
      end
      ERASE: begin
        if (fl.erase_success == 2'd1) begin
          pass_hit   = 1'b1;
          state_next = GAP;
        end else if (fl.erase_success == 2'd2) begin
          fail_hit   = 1'b1;
          state_next = MARK;
        end else if (fl.erase_success == 2'd0 && tmo_reg == TIMEOUT_CYCLES - 20'd1) begin
          tmo_hit    = 1'b1;
          state_next = MARK;
        end
      end
      MARK:  state_next = GAP;
      // abort is only honoured here, so a started physical erase always finishes
      GAP:   state_next = (remaining_reg == 13'd1 || abort) ? DONE : CHECK;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      block_reg     <= 12'd0;
      remaining_reg <= 13'd0;
      tmo_reg       <= 20'd0;
      mark_reg      <= 1'b0;
      erased_reg    <= 13'd0;
      skipped_reg   <= 13'd0;
      failed_reg    <= 13'd0;
      timeout_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        block_reg     <= first_block;
        remaining_reg <= block_count;
        mark_reg      <= mark_bad_en;
        erased_reg    <= 13'd0;
        skipped_reg   <= 13'd0;
        failed_reg    <= 13'd0;
        timeout_reg   <= 1'b0;
      end else begin
        if (pass_hit) erased_reg <= erased_reg + 13'd1;
        if (skip_hit) skipped_reg <= skipped_reg + 13'd1;
        if (fail_hit || tmo_hit) failed_reg <= failed_reg + 13'd1;
        if (tmo_hit) timeout_reg <= 1'b1;
      end
      if (state_reg == CHECK) tmo_reg <= 20'd0;
      else if (state_reg == ERASE) tmo_reg <= tmo_reg + 20'd1;
      if (state_reg == GAP) begin
        remaining_reg <= remaining_reg - 13'd1;
        block_reg     <= block_reg + 12'd1;
      end
    end
  end

  assign fl.en_erase_page  = (state_reg == CHECK) || (state_reg == ERASE);
  assign fl.erase_addr_row = {5'b0, block_reg, 7'b0};
  assign fl.bbt_wr_en      = (state_reg == MARK) && mark_reg;
  assign fl.bbt_wr_addr    = block_reg;
  assign fl.bbt_wr_data    = 1'b1;

  assign busy         = (state_reg != IDLE);
  assign done         = (state_reg == DONE);
  assign erased_cnt   = erased_reg;
  assign skipped_cnt  = skipped_reg;
  assign failed_cnt   = failed_reg;
  assign timeout_flag = timeout_reg;

endmodule

// File: tb/tb_erase_sched.sv
// Scoreboard bench for erase_sched: a flash responder model, a sequence-level
// reference model feeding expectation queues, and a monitor that checks them.
module tb_erase_sched;
  localparam logic [19:0] TMO = 20'd100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [11:0] first_block = 12'd0;
  logic [12:0] block_count = 13'd0;
  logic        mark_bad_en = 1'b0;
  logic        abort = 1'b0;
  logic        busy, done, timeout_flag;
  logic [12:0] erased_cnt, skipped_cnt, failed_cnt;

  erase_sched_if fl();

  erase_sched #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .first_block(first_block),
    .block_count(block_count), .mark_bad_en(mark_bad_en), .abort(abort),
    .fl(fl), .busy(busy), .done(done), .erased_cnt(erased_cnt),
    .skipped_cnt(skipped_cnt), .failed_cnt(failed_cnt), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  typedef struct {int erased; int skipped; int failed; int tmo;} stats_t;

  int          chk_cnt = 0;
  int          err_cnt = 0;
  bit          mon_en  = 1'b1;
  // per-block flash behaviour: bad flag, result (0 pass, 1 fail, 2 hang), latency
  bit          cfg_bad [4096];
  int          cfg_res [4096];
  int          cfg_lat [4096];
  logic [23:0] row_q [$];
  int          gap_q [$];
  logic [11:0] bbt_q [$];
  stats_t      stats_q [$];

  task automatic chk(input string name, input longint act, input longint exp);
    chk_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag_unexpected(input string name);
    chk_cnt++;
    err_cnt++;
    $display("FAIL %s: DUT event with nothing expected", name);
  endtask

  // erase_flash stand-in: verdict 2 cycles after enable rises, status after latency
  initial begin
    int cnt;
    int b;
    cnt = 0;
    fl.erase_addr_row_error = 2'd0;
    fl.erase_success = 2'd0;
    forever begin
      @(negedge clk);
      if (!fl.en_erase_page) begin
        cnt = 0;
        fl.erase_addr_row_error = 2'd0;
        fl.erase_success = 2'd0;
      end else begin
        cnt++;
        b = int'(fl.erase_addr_row[18:7]);
        if (cnt >= 2) fl.erase_addr_row_error = cfg_bad[b] ? 2'd2 : 2'd1;
        if (cnt >= 2 + cfg_lat[b] && !cfg_bad[b] && cfg_res[b] != 2)
          fl.erase_success = (cfg_res[b] == 1) ? 2'd2 : 2'd1;
      end
    end
  end

  // monitor: pops expectations whenever the DUT presents a row, a BBT write or done
  initial begin
    logic   en_prev;
    int     low_len;
    bit     first;
    stats_t s;
    en_prev = 1'b0;
    low_len = 0;
    first   = 1'b1;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        en_prev = fl.en_erase_page;
        low_len = 0;
        first   = 1'b1;
      end else begin
        if (fl.en_erase_page && !en_prev) begin
          if (row_q.size() == 0) flag_unexpected("row");
          else chk("row", fl.erase_addr_row, row_q.pop_front());
          if (!first) begin
            if (gap_q.size() == 0) flag_unexpected("gap");
            else chk("en_low_gap", low_len, gap_q.pop_front());
          end
          first   = 1'b0;
          low_len = 0;
        end else if (!fl.en_erase_page) begin
          low_len++;
        end
        if (fl.bbt_wr_en) begin
          if (bbt_q.size() == 0) flag_unexpected("bbt_wr");
          else chk("bbt_wr_addr", fl.bbt_wr_addr, bbt_q.pop_front());
          chk("bbt_wr_data", fl.bbt_wr_data, 1);
        end
        if (done) begin
          if (stats_q.size() == 0) flag_unexpected("done");
          else begin
            s = stats_q.pop_front();
            chk("erased_cnt", erased_cnt, s.erased);
            chk("skipped_cnt", skipped_cnt, s.skipped);
            chk("failed_cnt", failed_cnt, s.failed);
            chk("timeout_flag", timeout_flag, s.tmo);
          end
          $display("seq done: erased=%0d skipped=%0d failed=%0d timeout=%0d",
                   erased_cnt, skipped_cnt, failed_cnt, timeout_flag);
          first = 1'b1;
        end
        en_prev = fl.en_erase_page;
      end
    end
  end

  task automatic set_blk(input int b, input bit bad, input int res, input int lat);
    cfg_bad[b % 4096] = bad;
    cfg_res[b % 4096] = res;
    cfg_lat[b % 4096] = lat;
  endtask

  // reference model at sequence level, then drive one sequence and wait for done
  task automatic run_seq(input int fb, input int cnt, input bit mark, input int abort_at,
                         input bit dup_start, output int hi_cycles, output int done_cyc);
    stats_t s;
    int     n, b, cyc, rises;
    bit     prev_failed, en_p, got_done;
    s = '{0, 0, 0, 0};
    prev_failed = 1'b0;
    n = (abort_at >= 0 && abort_at < cnt) ? abort_at + 1 : cnt;
    for (int i = 0; i < n; i++) begin
      b = (fb + i) % 4096;
      row_q.push_back(24'(b) << 7);
      if (i > 0) gap_q.push_back(prev_failed ? 2 : 1);
      if (cfg_bad[b]) begin
        s.skipped++;
        prev_failed = 1'b0;
      end else if (cfg_res[b] == 0) begin
        s.erased++;
        prev_failed = 1'b0;
      end else begin
        s.failed++;
        if (cfg_res[b] == 2) s.tmo = 1;
        if (mark) bbt_q.push_back(12'(b));
        prev_failed = 1'b1;
      end
    end
    stats_q.push_back(s);

    @(negedge clk);
    first_block = 12'(fb);
    block_count = 13'(cnt);
    mark_bad_en = mark;
    start = 1'b1;
    cyc = 0; rises = 0; en_p = 1'b0; got_done = 1'b0;
    hi_cycles = 0; done_cyc = -1;
    while (!got_done && cyc <= cnt * 250 + 30) begin
      @(negedge clk);
      if (cyc == 0) start = 1'b0;
      if (dup_start && cyc == 4) begin
        start = 1'b1;
        first_block = 12'(fb + 7);
        block_count = 13'd9;
      end
      if (dup_start && cyc == 5) start = 1'b0;
      if (fl.en_erase_page) hi_cycles++;
      if (fl.en_erase_page && !en_p) begin
        rises++;
        if (abort_at >= 0 && rises == abort_at + 1) abort = 1'b1;
      end
      en_p = fl.en_erase_page;
      if (done) begin
        got_done = 1'b1;
        done_cyc = cyc;
      end
      cyc++;
    end
    abort = 1'b0;
    chk("done_seen", got_done, 1);
    @(negedge clk);
    chk("busy_after_done", busy, 0);
    chk("rows_left", row_q.size(), 0);
    chk("bbt_left", bbt_q.size(), 0);
    chk("stats_left", stats_q.size(), 0);
    row_q.delete(); gap_q.delete(); bbt_q.delete(); stats_q.delete();
  endtask

  initial begin
    int  hi, dc, fb, cnt, ab, pulses, r;
    bit  got;
    for (int i = 0; i < 4096; i++) set_blk(i, 1'b0, 0, 3);

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_en", fl.en_erase_page, 0);
    chk("rst_row", fl.erase_addr_row, 0);
    chk("rst_bbt_en", fl.bbt_wr_en, 0);
    chk("rst_bbt_addr", fl.bbt_wr_addr, 0);
    chk("rst_bbt_data", fl.bbt_wr_data, 1);
    chk("rst_erased", erased_cnt, 0);
    chk("rst_skipped", skipped_cnt, 0);
    chk("rst_failed", failed_cnt, 0);
    chk("rst_tmo", timeout_flag, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // three good blocks, 20-cycle erase each: 2 CHECK + 20 ERASE cycles per block
    for (int i = 10; i < 13; i++) set_blk(i, 1'b0, 0, 20);
    run_seq(10, 3, 1'b0, -1, 1'b0, hi, dc);
    chk("t1_en_high_cycles", hi, 66);

    // block 11 bad
    set_blk(11, 1'b1, 0, 20);
    run_seq(10, 3, 1'b0, -1, 1'b0, hi, dc);

    // block 10 fails with marking
    set_blk(11, 1'b0, 0, 20);
    set_blk(10, 1'b0, 1, 5);
    run_seq(10, 3, 1'b1, -1, 1'b0, hi, dc);

    // block 10 hangs: 2 CHECK + 100 ERASE cycles before timeout
    set_blk(10, 1'b0, 2, 0);
    run_seq(10, 1, 1'b1, -1, 1'b0, hi, dc);
    chk("t4_en_high_cycles", hi, 102);
    set_blk(10, 1'b0, 0, 20);

    // wrap 4095 -> 0
    run_seq(4095, 2, 1'b0, -1, 1'b0, hi, dc);

    // zero-length sequence
    run_seq(200, 0, 1'b0, -1, 1'b0, hi, dc);
    chk("t6_en_high_cycles", hi, 0);
    chk("t6_done_latency", dc, 0);

    // abort during block 1 of 5
    for (int i = 0; i < 5; i++) set_blk(i, 1'b0, 0, 10);
    run_seq(0, 5, 1'b0, 1, 1'b0, hi, dc);

    // start while busy is ignored
    run_seq(10, 3, 1'b0, -1, 1'b1, hi, dc);

    // reset mid-ERASE
    mon_en = 1'b0;
    set_blk(100, 1'b0, 0, 50);
    @(negedge clk);
    first_block = 12'd100; block_count = 13'd3; mark_bad_en = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (fl.en_erase_page && fl.erase_addr_row_error == 2'd1) got = 1'b1;
    end
    chk("rst_reach_erase", got, 1);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_en", fl.en_erase_page, 0);
    chk("mid_rst_row", fl.erase_addr_row, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_erased", erased_cnt, 0);
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("no_done_after_rst", pulses, 0);
    chk("idle_after_rst", busy, 0);
    mon_en = 1'b1;
    @(negedge clk);

    // randomized sequences
    for (int t = 0; t < 20; t++) begin
      fb  = int'($urandom_range(0, 4095));
      cnt = int'($urandom_range(1, 6));
      for (int i = 0; i < cnt; i++) begin
        r = int'($urandom_range(0, 9));
        set_blk(fb + i, ($urandom_range(0, 3) == 0), (r < 7) ? 0 : (r < 9) ? 1 : 2,
                int'($urandom_range(0, 15)));
      end
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, cnt - 1)) : -1;
      run_seq(fb, cnt, 1'($urandom_range(0, 1)), ab, 1'b0, hi, dc);
    end

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end
endmodule
